// File: rtl/sap_pkg.sv
// Shared constants and types for the bus-based datapath.
// Build option: OPERAND_REGS_FLAGS_EN enables the flag and contention registers in operand_regs.
package sap_pkg;

  localparam int unsigned SAP_WIDTH = 8;

  localparam logic [SAP_WIDTH-1:0] BUS_IDLE  = {SAP_WIDTH{1'bz}};
  localparam logic [SAP_WIDTH-1:0] RESET_VAL = '0;

  typedef struct packed {
    logic carry;
    logic zero;
    logic contention;
  } flags_t;

  // Case equality keeps a floating or unknown bus from reading as zero.
  function automatic logic bus_is_zero(input logic [SAP_WIDTH-1:0] v);
    return (v === '0);
  endfunction

endpackage

// File: rtl/bus_register.sv
// WIDTH-bit register with async active-low clear and active-low load enable.
module bus_register
  import sap_pkg::*;
#(
  parameter int unsigned WIDTH = SAP_WIDTH
) (
  input  logic             clk,
  input  logic             clrbar,
  input  logic             load_bar,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!load_bar) q_d = d;
  end

  always_ff @(posedge clk or negedge clrbar) begin
    if (!clrbar) q_q <= RESET_VAL;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/operand_regs.sv
// A/B operand registers for the ALU, with A bus driver and optional carry/zero/contention flags.
// Build option: define OPERAND_REGS_FLAGS_EN to include the flag and contention registers.
module operand_regs
  import sap_pkg::*;
#(
  parameter int unsigned WIDTH = SAP_WIDTH
) (
  input  logic             clk,
  input  logic             clrbar,
  inout  logic [WIDTH-1:0] bus,
  input  logic             la_bar,
  input  logic             lb_bar,
  input  logic             ea,
  input  logic             lf_bar,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             contention
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;

  // While A drives the bus, a self-load takes A directly so the result never depends on bus resolution.
  assign a_d = ea ? a_q : bus;

  bus_register #(.WIDTH(WIDTH)) u_reg_a (
    .clk      (clk),
    .clrbar   (clrbar),
    .load_bar (la_bar),
    .d        (a_d),
    .q        (a_q)
  );

  bus_register #(.WIDTH(WIDTH)) u_reg_b (
    .clk      (clk),
    .clrbar   (clrbar),
    .load_bar (lb_bar),
    .d        (bus),
    .q        (b_q)
  );

  assign bus   = ea ? a_q : BUS_IDLE;
  assign a_out = a_q;
  assign b_out = b_q;

`ifdef OPERAND_REGS_FLAGS_EN
  flags_t flags_q;
  flags_t flags_d;

  always_comb begin
    flags_d            = flags_q;
    flags_d.contention = ea & ~la_bar;
    if (!lf_bar) begin
      flags_d.carry = alu_cout;
      flags_d.zero  = bus_is_zero(bus);
    end
  end

  always_ff @(posedge clk or negedge clrbar) begin
    if (!clrbar) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign carry_flag = flags_q.carry;
  assign zero_flag  = flags_q.zero;
  assign contention = flags_q.contention;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = lf_bar ^ alu_cout;

  assign carry_flag = 1'b0;
  assign zero_flag  = 1'b0;
  assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_operand_regs.sv
// Directed self-checking bench for operand_regs; expectations follow OPERAND_REGS_FLAGS_EN.
module tb_operand_regs;

`ifdef OPERAND_REGS_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic       clk;
  logic       clrbar;
  logic       la_bar, lb_bar, ea, lf_bar, alu_cout;
  logic       tb_oe;
  logic [7:0] tb_bus;
  wire  [7:0] bus;
  logic [7:0] a_out, b_out;
  logic       carry_flag, zero_flag, contention;

  int unsigned checks;
  int unsigned errors;

  assign bus = tb_oe ? tb_bus : 8'hzz;

  operand_regs #(.WIDTH(8)) dut (
    .clk        (clk),
    .clrbar     (clrbar),
    .bus        (bus),
    .la_bar     (la_bar),
    .lb_bar     (lb_bar),
    .ea         (ea),
    .lf_bar     (lf_bar),
    .alu_cout   (alu_cout),
    .a_out      (a_out),
    .b_out      (b_out),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .contention (contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    la_bar = 1'b1; lb_bar = 1'b1; lf_bar = 1'b1;
    ea = 1'b0; tb_oe = 1'b0; alu_cout = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    clrbar = 1'b0; tb_bus = 8'h00;
    idle();
    step(); step();
    check("rst_a", a_out, 8'h00);
    check("rst_b", b_out, 8'h00);
    check("rst_carry", carry_flag, 1'b0);
    check("rst_zero", zero_flag, 1'b0);
    check("rst_cont", contention, 1'b0);
    clrbar = 1'b1;

    // Load A then B
    tb_oe = 1'b1; tb_bus = 8'h45; la_bar = 1'b0;
    step();
    check("load_a", a_out, 8'h45);
    la_bar = 1'b1; tb_bus = 8'h07; lb_bar = 1'b0;
    step();
    check("load_b", b_out, 8'h07);
    check("load_a_hold", a_out, 8'h45);
    idle();
    step();
    check("hold_b", b_out, 8'h07);
    ea = 1'b1; #1;
    check("bus_drive_a", bus, 8'h45);
    ea = 1'b0;

    // Add write-back: 0x45 + 0x07 = 0x4C
    tb_oe = 1'b1; tb_bus = 8'h4C; la_bar = 1'b0; lf_bar = 1'b0; alu_cout = 1'b0;
    step();
    check("add_a", a_out, 8'h4C);
    check("add_carry", carry_flag, 1'b0);
    check("add_zero", zero_flag, 1'b0);
    check("add_cont", contention, 1'b0);

    // Subtract to zero: A=B=0x21 loaded together, result 0x00 with cout=1
    idle(); tb_oe = 1'b1; tb_bus = 8'h21; la_bar = 1'b0; lb_bar = 1'b0;
    step();
    check("both_a", a_out, 8'h21);
    check("both_b", b_out, 8'h21);
    idle(); tb_oe = 1'b1; tb_bus = 8'h00; alu_cout = 1'b1; lf_bar = 1'b0;
    step();
    check("sub_zero", zero_flag, FL);
    check("sub_carry", carry_flag, FL);
    check("sub_a_hold", a_out, 8'h21);

    // Flags hold while lf_bar high
    idle(); tb_oe = 1'b1; tb_bus = 8'h55; alu_cout = 1'b0;
    step();
    check("hold_zero", zero_flag, FL);
    check("hold_carry", carry_flag, FL);

    // Contention: A drives bus while loading from it
    idle(); tb_oe = 1'b1; tb_bus = 8'h1E; la_bar = 1'b0;
    step();
    check("cont_pre_a", a_out, 8'h1E);
    idle(); ea = 1'b1; la_bar = 1'b0;
    step();
    check("cont_a", a_out, 8'h1E);
    check("cont_bus", bus, 8'h1E);
    check("cont_flag", contention, FL);
    la_bar = 1'b1;
    step();
    check("cont_clear", contention, 1'b0);
    check("cont_a_after", a_out, 8'h1E);

    // Async reset mid-cycle after loading A=0x45
    idle(); tb_oe = 1'b1; tb_bus = 8'h45; la_bar = 1'b0;
    step();
    check("pre_rst_a", a_out, 8'h45);
    idle();
    #2 clrbar = 1'b0;
    #1;
    check("async_a", a_out, 8'h00);
    check("async_b", b_out, 8'h00);
    check("async_carry", carry_flag, 1'b0);
    check("async_zero", zero_flag, 1'b0);
    ea = 1'b1; #1;
    check("async_bus", bus, 8'h00);
    ea = 1'b0;
    step();
    clrbar = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
